// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_pkg
// Brief    : Shared types and widths for the data-memory request/response bus.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = WORD_BYTES * BYTE_W;
    localparam int BE_W       = WORD_BYTES;
    localparam int WIDX_W     = ADDR_W - 2;   // width of the word index addr[31:2]
    localparam int CNT_W      = 4;            // wait counter; LATENCY <= 15 never wraps

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Misaligned or beyond the last stored word (unsigned word-index compare).
    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr,
                                      input logic [WIDX_W-1:0] depth);
        return (addr[1:0] != 2'b00) || (addr[ADDR_W-1:2] >= depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_word_array
// Brief    : Single-port synchronous word array, per-byte write enables,
//            registered read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module mem_word_array
    import mem_bus_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [BE_W-1:0]   we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write and registered read; rdata holds between reads.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (we[b]) begin
                mem[addr][BYTE_W*b +: BYTE_W] <= wdata[BYTE_W*b +: BYTE_W];
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Memory-side responder for the CPU data port. One outstanding
//            request, fixed wait-state latency, valid/ready on both channels.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BE_W-1:0]   req_be,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error
);

    localparam int                IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LATENCY - 1);
    localparam bit                SKIP_WAIT = (LATENCY <= 1);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic                enter_resp;

    logic                lat_write;
    logic [ADDR_W-1:0]   lat_addr;
    logic [BE_W-1:0]     lat_be;
    logic [DATA_W-1:0]   lat_wdata;

    logic                acc_write;
    logic [ADDR_W-1:0]   acc_addr;
    logic [BE_W-1:0]     acc_be;
    logic [DATA_W-1:0]   acc_wdata;
    logic                acc_bad;

    logic                load_ok;
    logic                mem_go;
    logic                mem_rd;
    logic [BE_W-1:0]     mem_we;
    logic [DATA_W-1:0]   mem_rdata;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; handshake outputs depend on the state register only.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (SKIP_WAIT) begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // With a one-cycle latency the memory is accessed on the acceptance edge,
    // so the live request fields are used instead of the latched copy.
    assign acc_write = (state == ST_IDLE) ? req_write : lat_write;
    assign acc_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
    assign acc_be    = (state == ST_IDLE) ? req_be    : lat_be;
    assign acc_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;
    assign acc_bad   = addr_bad(acc_addr, DEPTH_LIM);

    // Reset on the commit edge must drop an uncommitted store.
    assign mem_go = enter_resp && !acc_bad && !reset;
    assign mem_rd = mem_go && !acc_write;
    assign mem_we = (mem_go && acc_write) ? acc_be : '0;

    // Latch the accepted request; no reset needed, only read after acceptance.
    always_ff @(posedge clock) begin
        if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_be    <= req_be;
            lat_wdata <= req_wdata;
        end
    end

    // Wait counter and response status, captured on the edge entering RESP.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            load_ok   <= 1'b0;
            rsp_error <= 1'b0;
        end else begin
            if (accept || enter_resp) begin
                cnt <= '0;
            end else if (state == ST_WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (enter_resp) begin
                load_ok   <= !acc_write && !acc_bad;
                rsp_error <= acc_bad;
            end
        end
    end

    // Read data is only exposed for a successful load; stores and errors return 0.
    assign rsp_rdata = load_ok ? mem_rdata : '0;

    mem_word_array #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clock),
        .rd_en (mem_rd),
        .we    (mem_we),
        .addr  (acc_addr[2 +: IDX_W]),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed self-checking bench for data_mem_responder
//            (DEPTH_WORDS = 256, LATENCY = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] rd;
    logic        err;
    int          cyc;

    data_mem_responder #(
        .DEPTH_WORDS (256),
        .LATENCY     (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive a request (called 1 time unit after an edge); returns 1 unit after acceptance edge.
    task automatic send(input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
        int guard;
        req_write = wr;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wd;
        req_valid = 1'b1;
        guard     = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 50) begin
            vectors++;
            errors++;
            $display("FAIL send_timeout: req_ready=%b required 1", req_ready);
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for the response, report edges since acceptance, then handshake it.
    task automatic get_rsp(output logic [31:0] o_rd, output logic o_err, output int o_cyc);
        o_cyc = 0;
        while (!rsp_valid && o_cyc < 40) begin
            @(posedge clock); #1;
            o_cyc++;
        end
        if (!rsp_valid) begin
            vectors++;
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
        end
        o_rd      = rsp_rdata;
        o_err     = rsp_error;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        vectors++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        vectors++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        vectors++;
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 00000000", rsp_rdata); end
        vectors++;
        if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_error: got %b expected 0", rsp_error); end
    endtask

    task automatic test_store_load();
        send(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        vectors++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_req_ready: got %b expected 0", req_ready); end
        get_rsp(rd, err, cyc);
        vectors++;
        if (cyc !== 2) begin errors++; $display("FAIL store_latency: got %0d expected 2", cyc); end
        vectors++;
        if (err !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL store_rsp: got err=%b rdata=%h expected err=0 rdata=00000000", err, rd); end
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL post_handshake: got valid=%b ready=%b expected 0 1", rsp_valid, req_ready); end
        send(1'b0, 32'h10, 4'h0, 32'h0);
        get_rsp(rd, err, cyc);
        vectors++;
        if (cyc !== 2) begin errors++; $display("FAIL load_latency: got %0d expected 2", cyc); end
        vectors++;
        if (err !== 1'b0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_full: got err=%b rdata=%h expected err=0 rdata=deadbeef", err, rd); end
    endtask

    task automatic test_partial_store();
        send(1'b1, 32'h10, 4'h5, 32'h11223344);
        get_rsp(rd, err, cyc);
        vectors++;
        if (err !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL partial_store_rsp: got err=%b rdata=%h expected err=0 rdata=00000000", err, rd); end
        send(1'b0, 32'h10, 4'h0, 32'h0);
        get_rsp(rd, err, cyc);
        vectors++;
        if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL partial_load: got %h expected de22be44", rd); end
        // be = 0 store is a no-op that is still acknowledged
        send(1'b1, 32'h10, 4'h0, 32'hFFFFFFFF);
        get_rsp(rd, err, cyc);
        vectors++;
        if (cyc !== 2 || err !== 1'b0) begin errors++; $display("FAIL be0_ack: got cyc=%0d err=%b expected cyc=2 err=0", cyc, err); end
        send(1'b0, 32'h10, 4'h0, 32'h0);
        get_rsp(rd, err, cyc);
        vectors++;
        if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL be0_load: got %h expected de22be44", rd); end
    endtask

    task automatic test_errors();
        send(1'b1, 32'h0, 4'hF, 32'hCAFEF00D);
        get_rsp(rd, err, cyc);
        send(1'b1, 32'h3FC, 4'hF, 32'h0BADF00D);
        get_rsp(rd, err, cyc);
        vectors++;
        if (err !== 1'b0) begin errors++; $display("FAIL last_word_store: got err=%b expected 0", err); end
        send(1'b0, 32'h3FC, 4'h0, 32'h0);
        get_rsp(rd, err, cyc);
        vectors++;
        if (err !== 1'b0 || rd !== 32'h0BADF00D) begin errors++; $display("FAIL last_word_load: got err=%b rdata=%h expected err=0 rdata=0badf00d", err, rd); end
        send(1'b0, 32'h12, 4'h0, 32'h0);
        get_rsp(rd, err, cyc);
        vectors++;
        if (err !== 1'b1 || rd !== 32'h0 || cyc !== 2) begin errors++; $display("FAIL misaligned_load: got err=%b rdata=%h cyc=%0d expected err=1 rdata=00000000 cyc=2", err, rd, cyc); end
        send(1'b0, 32'h400, 4'h0, 32'h0);
        get_rsp(rd, err, cyc);
        vectors++;
        if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL range_load: got err=%b rdata=%h expected err=1 rdata=00000000", err, rd); end
        send(1'b0, 32'hFFFFFFFC, 4'h0, 32'h0);
        get_rsp(rd, err, cyc);
        vectors++;
        if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL top_addr_load: got err=%b rdata=%h expected err=1 rdata=00000000", err, rd); end
        send(1'b1, 32'h400, 4'hF, 32'h0);
        get_rsp(rd, err, cyc);
        vectors++;
        if (err !== 1'b1) begin errors++; $display("FAIL range_store: got err=%b expected 1", err); end
        send(1'b1, 32'h12, 4'hF, 32'h0);
        get_rsp(rd, err, cyc);
        vectors++;
        if (err !== 1'b1) begin errors++; $display("FAIL misaligned_store: got err=%b expected 1", err); end
        send(1'b0, 32'h0, 4'h0, 32'h0);
        get_rsp(rd, err, cyc);
        vectors++;
        if (err !== 1'b0 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL word0_intact: got err=%b rdata=%h expected err=0 rdata=cafef00d", err, rd); end
        send(1'b0, 32'h10, 4'h0, 32'h0);
        get_rsp(rd, err, cyc);
        vectors++;
        if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL word4_intact: got %h expected de22be44", rd); end
    endtask

    task automatic test_backpressure();
        send(1'b0, 32'h10, 4'h0, 32'h0);
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
        end
        vectors++;
        if (cyc !== 2) begin errors++; $display("FAIL bp_latency: got %0d expected 2", cyc); end
        // a request offered while busy must be ignored
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_be    = 4'hF;
        req_wdata = 32'hFFFFFFFF;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22BE44 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h ready=%b expected 1 de22be44 0", i, rsp_valid, rsp_rdata, req_ready);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", rsp_valid, req_ready); end
        send(1'b0, 32'h10, 4'h0, 32'h0);
        get_rsp(rd, err, cyc);
        vectors++;
        if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL bp_ignored_req: got %h expected de22be44", rd); end
    endtask

    task automatic test_reset_in_wait();
        send(1'b1, 32'h20, 4'hF, 32'h01020304);
        get_rsp(rd, err, cyc);
        send(1'b1, 32'h20, 4'hF, 32'h55AA55AA);
        @(posedge clock); #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL wait_state: got valid=%b ready=%b expected 0 0", rsp_valid, req_ready); end
        // reset spans the edge that would otherwise commit the store
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL wait_reset: got ready=%b valid=%b err=%b expected 1 0 0", req_ready, rsp_valid, rsp_error);
        end
        send(1'b0, 32'h20, 4'h0, 32'h0);
        get_rsp(rd, err, cyc);
        vectors++;
        if (err !== 1'b0 || rd !== 32'h01020304) begin errors++; $display("FAIL store_discarded: got err=%b rdata=%h expected err=0 rdata=01020304", err, rd); end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_be    = 4'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_partial_store();
        test_errors();
        test_backpressure();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to have finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipelined CPU's data-memory port.
- Accepts one load/store request at a time over a valid/ready request channel.
- Inserts a configurable wait-state latency, then returns read data or a write acknowledgement over a valid/ready response channel.
- Replaces the zero-latency combinational data memory, so the MEM stage can later be stalled on a realistic memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; legal word indices 0..DEPTH_WORDS-1.
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_be  input  4  byte enables for stores; bit i covers bits [8i+7:8i].
- req_wdata  input  32  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_error  output  1  1 = misaligned or out-of-range access.

Behaviour:
- Reset (synchronous, active-high) sets: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, wait counter = 0.
- Memory array contents are not reset.
- Any transaction in flight is discarded on reset, including an uncommitted store.
- FSM states:
  - IDLE: req_ready = 1. Acceptance occurs when req_valid && req_ready at a clock edge. On acceptance, latch write, addr, be and wdata. Go to WAIT if LATENCY > 1, else go to RESP.
  - WAIT: req_ready = 0. Counter counts 1..LATENCY-1. When it reaches LATENCY-1, go to RESP at the next edge.
  - RESP: rsp_valid = 1. Hold rsp_rdata and rsp_error stable until rsp_valid && rsp_ready at an edge, then go to IDLE.
- req_ready is driven only by the state register; it has no combinational path from req_valid.
- Memory access happens on the edge that enters RESP:
  - Load: rsp_rdata is registered from mem[addr[31:2]].
  - Store: update only the bytes enabled in req_be. req_be = 0 is a legal no-op and is still acknowledged.
- Timing:
  - Acceptance at edge N gives rsp_valid high from edge N+LATENCY.
  - Earliest next acceptance is edge N+LATENCY+2 (one IDLE cycle after the response handshake).
  - Maximum throughput is one transaction per LATENCY+2 cycles.
- Errors:
  - addr[1:0] != 0, or addr[31:2] >= DEPTH_WORDS, sets rsp_error = 1 and rsp_rdata = 0.
  - No memory access occurs on an error; full latency and handshake still apply.
- Back-pressure: with rsp_ready low, stay in RESP indefinitely with outputs frozen.
- Request inputs are ignored outside IDLE.
- Only one transaction is outstanding, so a load always observes every prior acknowledged store.
- Arithmetic:
  - Word index = addr[31:2], compared as unsigned against DEPTH_WORDS.
  - Counter is 4 bits and never wraps, given LATENCY <= 15.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state encoding (IDLE, WAIT, RESP);
  - WORD_BYTES = 4;
  - request and response field widths.
- One sub-module, mem_word_array: a single-port synchronous word array with per-byte write enables and a registered read. It is instantiated by the responder.

Test Plan:
- Reset, then idle -> req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0.
- Store 0xDEADBEEF to 0x10 with be = 0xF, then load 0x10, LATENCY = 2 -> store response at acceptance+2 with error 0; load returns 0xDEADBEEF.
- Store 0x11223344 to 0x10 with be = 0x5 over 0xDEADBEEF, then load -> 0xDE22BE44.
- Load from 0x12 (misaligned) and from 0x400 with DEPTH_WORDS = 256 -> each gives rsp_error = 1, rsp_rdata = 0, no memory change; a later load of 0x0 is unaffected.
- Hold rsp_ready low for 5 cycles during a load -> rsp_valid and rsp_rdata held constant, req_ready = 0; handshake on cycle 6, req_ready = 1 on the following cycle.
- Accept a store to 0x20, then assert reset in WAIT -> next cycle req_ready = 1, rsp_valid = 0; a subsequent load of 0x20 returns the pre-store contents.
